// File: rtl/pwm_multi_ch_if.sv
// ---------------------------------------------------------------------------
// pwm_multi_ch_if
// Duty-write handshake bundle for pwm_multi_ch.
//   wr_valid_i : requester has a duty write pending
//   wr_ready_o : block can take a write this cycle
//   wr_ch_i    : target channel index (indices >= CH are accepted and dropped)
//   wr_duty_i  : duty value, CW bits
// master = register/control side, slave = PWM block.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface pwm_multi_ch_if #(
   parameter int CH = 3,
   parameter int CW = 8
);
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

   logic           wr_valid_i;
   logic           wr_ready_o;
   logic [CHW-1:0] wr_ch_i;
   logic [CW-1:0]  wr_duty_i;

   modport master (output wr_valid_i, output wr_ch_i, output wr_duty_i, input  wr_ready_o);
   modport slave  (input  wr_valid_i, input  wr_ch_i, input  wr_duty_i, output wr_ready_o);
endinterface

// File: rtl/pwm_multi_ch.sv
// ---------------------------------------------------------------------------
// pwm_multi_ch
// Multi-channel PWM generator. One shared prescaler and period counter feed
// CH per-channel comparator lanes. Duty writes land in a per-lane shadow
// register and are committed to the active register at the period boundary,
// so an output never shows a pulse of intermediate length.
// Modes: standard PWM (thr = duty) and servo mapping
// (thr = SERVO_MIN + duty*SERVO_SPAN/2^CW, saturated).
//
// Ports:
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   en_i            : run enable; low holds counters at 0 and outputs low
//   mode_i          : 0 = standard, 1 = servo (taken at period boundary)
//   wr              : duty-write handshake (pwm_multi_ch_if.slave)
//   pwm_o           : registered PWM outputs, bit n = channel n
//   period_tick_o   : one-cycle pulse in the first cycle of each period
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

// Per-channel lane: shadow/active duty, threshold mapping, output register.
//   i_commit : copy shadow to active if a write is pending
//   i_wr     : accept i_duty into the shadow register
//   i_servo  : registered mode, selects the servo threshold mapping
//   i_d      : shared period counter
//   o_pwm    : registered channel output
module pwm_multi_ch_lane #(
   parameter int CW         = 8,
   parameter int SERVO_MIN  = 13,
   parameter int SERVO_SPAN = 13
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   input  logic          i_commit,
   input  logic          i_wr,
   input  logic [CW-1:0] i_duty,
   input  logic          i_servo,
   input  logic [CW-1:0] i_d,
   output logic          o_pwm
);
   // Wide enough for duty*SPAN plus the offset before saturation.
   localparam int TW = CW + $clog2(SERVO_SPAN + 1) + 1;

   logic [CW-1:0] r_pend;
   logic [CW-1:0] r_act;
   logic          r_dirty;

   logic [TW-1:0] w_prod;
   logic [TW-1:0] w_servo;
   logic [CW-1:0] w_thr;

   always_comb begin
      w_prod  = TW'(r_act) * TW'(SERVO_SPAN);
      w_servo = TW'(SERVO_MIN) + (w_prod >> CW);
      w_thr   = r_act;
      if (i_servo) begin
         if (|w_servo[TW-1:CW]) w_thr = '1;
         else                   w_thr = w_servo[CW-1:0];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pend  <= '0;
         r_act   <= '0;
         r_dirty <= 1'b0;
         o_pwm   <= 1'b0;
      end else begin
         if (i_commit && r_dirty) begin
            r_act   <= r_pend;
            r_dirty <= 1'b0;
         end
         // A write in the same cycle as a commit re-arms dirty for the next one.
         if (i_wr) begin
            r_pend  <= i_duty;
            r_dirty <= 1'b1;
         end
         o_pwm <= i_en && (i_d < w_thr);
      end
   end
endmodule

module pwm_multi_ch #(
   parameter int CH         = 3,
   parameter int CW         = 8,
   parameter int PW         = 32,
   parameter int DIV_STD    = 10416,
   parameter int DIV_SERVO  = 200000,
   parameter int SERVO_MIN  = 13,
   parameter int SERVO_SPAN = 13
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic          mode_i,
   pwm_multi_ch_if.slave wr,
   output logic [CH-1:0] pwm_o,
   output logic          period_tick_o
);
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [PW-1:0] STD_M1   = PW'(DIV_STD - 1);
   localparam logic [PW-1:0] SERVO_M1 = PW'(DIV_SERVO - 1);

   logic [PW-1:0] r_q;
   logic [CW-1:0] r_d;
   logic          r_mode;
   logic          r_tick;

   logic [PW-1:0] w_div_m1;
   logic          w_tick;
   logic          w_boundary;
   logic          w_commit;
   logic          w_xfer;
   logic [CH-1:0] w_wr;

   assign w_div_m1   = r_mode ? SERVO_M1 : STD_M1;
   assign w_tick     = en_i && (r_q == w_div_m1);
   assign w_boundary = w_tick && (r_d == '1);
   // While disabled there is no period, so writes go straight through.
   assign w_commit   = w_boundary || !en_i;

   // Holding ready low in the boundary cycle keeps writes and commits apart.
   assign wr.wr_ready_o = !rst_i && !w_boundary;
   assign w_xfer        = wr.wr_valid_i && wr.wr_ready_o;
   assign period_tick_o = r_tick;

   // Channel decode; indices >= CH match no lane and are dropped.
   always_comb begin
      w_wr = '0;
      for (int n = 0; n < CH; n++)
         w_wr[n] = w_xfer && (wr.wr_ch_i == CHW'(n));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_q    <= '0;
         r_d    <= '0;
         r_mode <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         if (!en_i) begin
            r_q <= '0;
            r_d <= '0;
         end else if (w_tick) begin
            r_q <= '0;
            r_d <= r_d + CW'(1);
         end else begin
            r_q <= r_q + PW'(1);
         end
         // Mode only moves between periods so the running one keeps its length.
         if (w_commit) r_mode <= mode_i;
         r_tick <= w_boundary;
      end
   end

   for (genvar n = 0; n < CH; n++) begin : g_lane
      pwm_multi_ch_lane #(
         .CW         (CW),
         .SERVO_MIN  (SERVO_MIN),
         .SERVO_SPAN (SERVO_SPAN)
      ) u_lane (
         .i_clk    (clk_i),
         .i_rst    (rst_i),
         .i_en     (en_i),
         .i_commit (w_commit),
         .i_wr     (w_wr[n]),
         .i_duty   (wr.wr_duty_i),
         .i_servo  (r_mode),
         .i_d      (r_d),
         .o_pwm    (pwm_o[n])
      );
   end
endmodule
